// File: rtl/return_address_stack.sv
// Return address stack for call/return target prediction.
//
// A circular buffer of DEPTH return addresses. wr_ptr points at the next free
// slot. count tracks how many entries are valid and saturates at DEPTH. When
// the stack is full, a further push overwrites the oldest entry.
//
// Ports:
//   clk           - clock; all state updates on the rising edge
//   reset         - asynchronous, active-high reset
//   push_en       - call decoded; save push_addr
//   push_addr     - return address (call pc+4)
//   pop_en        - return decoded; drop the top entry
//   restore_en    - mispredict; reload wr_ptr/count from the checkpoint
//                   (takes priority over push/pop)
//   restore_ptr   - wr_ptr checkpoint
//   restore_count - count checkpoint (values above DEPTH are clamped)
//   ras_valid     - stack non-empty
//   ras_target    - top-of-stack address (combinational)
//   ckpt_ptr      - current wr_ptr, carried with each prediction
//   ckpt_count    - current count, carried with each prediction
//
// DEPTH must be a power of two and at least 2 so that pointer arithmetic can
// wrap naturally in $clog2(DEPTH) bits.
module return_address_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_en,
  input  logic [XLEN-1:0]            push_addr,
  input  logic                       pop_en,
  input  logic                       restore_en,
  input  logic [$clog2(DEPTH)-1:0]   restore_ptr,
  input  logic [$clog2(DEPTH):0]     restore_count,
  output logic                       ras_valid,
  output logic [XLEN-1:0]            ras_target,
  output logic [$clog2(DEPTH)-1:0]   ckpt_ptr,
  output logic [$clog2(DEPTH):0]     ckpt_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [XLEN-1:0] entries_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] top_idx;
  logic            we;
  logic [PtrW-1:0] waddr;
  logic            not_empty;

  // Power-of-two depth lets the subtraction wrap modulo DEPTH for free.
  assign top_idx   = wr_ptr_q - PtrW'(1);
  assign not_empty = (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    if (restore_en) begin
      wr_ptr_d = restore_ptr;
      count_d  = (restore_count > Full) ? Full : restore_count;
    end else if (push_en && pop_en && not_empty) begin
      // Co-routine jump: replace the top in place, depth unchanged.
      we    = 1'b1;
      waddr = top_idx;
    end else if (push_en) begin
      // Covers push+pop on an empty stack, which acts as a plain push.
      we       = 1'b1;
      waddr    = wr_ptr_q;
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      count_d  = (count_q == Full) ? Full : count_q + CntW'(1);
    end else if (pop_en && not_empty) begin
      wr_ptr_d = top_idx;
      count_d  = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else if (we) begin
      entries_q[waddr] <= push_addr;
    end
  end

  assign ras_valid  = not_empty;
  assign ras_target = entries_q[top_idx];
  assign ckpt_ptr   = wr_ptr_q;
  assign ckpt_count = count_q;

endmodule

// File: doc/return_address_stack.md
RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, giving the number of stack entries; the value SHALL be a power of two and at least 2.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port push_en, input, 1 bit: IF has decoded a call (JAL/JALR with rd=x1/x5).
REQ-005 The module SHALL have port push_addr, input, XLEN bits: return address to save (call pc+4).
REQ-006 The module SHALL have port pop_en, input, 1 bit: IF has decoded a return (JALR rs1=x1/x5, rd=x0).
REQ-007 The module SHALL have port restore_en, input, 1 bit: EX signals a mispredict and requests a stack-pointer restore.
REQ-008 The module SHALL have port restore_ptr, input, $clog2(DEPTH) bits: wr_ptr checkpoint to restore.
REQ-009 The module SHALL have port restore_count, input, $clog2(DEPTH)+1 bits: count checkpoint to restore.
REQ-010 The module SHALL have port ras_valid, output, 1 bit: stack non-empty; drives branch_predictor ras_valid.
REQ-011 The module SHALL have port ras_target, output, XLEN bits: top-of-stack address; drives branch_predictor ras_target.
REQ-012 The module SHALL have port ckpt_ptr, output, $clog2(DEPTH) bits: current wr_ptr, carried down the pipe with each prediction.
REQ-013 The module SHALL have port ckpt_count, output, $clog2(DEPTH)+1 bits: current count, carried with each prediction.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH XLEN-bit entries, with wr_ptr pointing at the next free slot and count equal to the number of valid entries (range 0..DEPTH).
REQ-015 ras_target SHALL equal entry[(wr_ptr-1) mod DEPTH] combinationally, and ras_valid SHALL be 1 exactly when count != 0.
REQ-016 ckpt_ptr and ckpt_count SHALL be the current registered wr_ptr and count, with no added latency.
REQ-017 On push only: entry[wr_ptr] <= push_addr, wr_ptr <= wr_ptr+1 mod DEPTH, count <= min(count+1, DEPTH); the new top SHALL be visible the following cycle.
REQ-018 On push when count==DEPTH: the oldest entry SHALL be silently overwritten (wrap-around) and count SHALL stay at DEPTH.
REQ-019 On pop only with count>0: wr_ptr <= wr_ptr-1 mod DEPTH, count <= count-1; entry contents SHALL be unchanged.
REQ-020 On pop only with count==0: no state change, and ras_valid SHALL remain 0.
REQ-021 On push and pop in the same cycle with count>0 (co-routine JALR): entry[(wr_ptr-1) mod DEPTH] <= push_addr, and wr_ptr and count SHALL be unchanged.
REQ-022 On push and pop in the same cycle with count==0: the operation SHALL behave as push only.
REQ-023 restore_en SHALL have priority over push_en and pop_en in the same cycle: wr_ptr <= restore_ptr, count <= restore_count, entries unchanged, and push and pop SHALL be ignored that cycle.
REQ-024 A restore_count value greater than DEPTH SHALL be clamped to DEPTH.

Reset
REQ-025 While reset is high, wr_ptr SHALL be 0, count SHALL be 0, and all entries SHALL be 0; the outputs SHALL therefore read ras_valid=0, ras_target=0, ckpt_ptr=0, ckpt_count=0.
REQ-026 Reset assertion SHALL take effect immediately, independent of clk, and SHALL abort any push, pop or restore in flight; no partial write SHALL survive.
REQ-027 The first rising edge after reset deasserts SHALL process inputs normally.

Verification (DEPTH=8, XLEN=32)
REQ-028 The bench SHALL cover push/pop order: push 0x100, 0x200, 0x300 on consecutive cycles -> ras_target 0x300; then pop, pop -> ras_target 0x200, then 0x100, with ras_valid=1 throughout.
REQ-029 The bench SHALL cover overflow: push 0x10..0x90 (9 pushes, step 0x10) -> count=8, top=0x90; after 8 pops, the last top seen SHALL be 0x20 (0x10 lost); after the 8th pop, ras_valid=0.
REQ-030 The bench SHALL cover underflow: from reset, pop for 3 cycles -> ras_valid=0, ckpt_ptr=0, ckpt_count=0 unchanged.
REQ-031 The bench SHALL cover simultaneous push+pop: with stack [0x100, 0x200], push 0x500 and pop together -> top=0x500, count=2; the following pop SHALL expose 0x100.
REQ-032 The bench SHALL cover restore priority: capture ckpt (ptr=2, count=2); then push 0xA0 and 0xB0; then assert restore_en with ptr=2, count=2 together with push 0xC0 -> top=0x200, count=2, and 0xC0 SHALL not be written.
REQ-033 The bench SHALL cover asynchronous reset mid-operation: assert reset between clock edges while push_en=1 -> outputs SHALL go to 0 before the next edge, and count SHALL be 0 after reset releases.
